// File: rtl/wl_afifo_rdstage.sv
// Read-side prefetch stage for an async FIFO: issues RAM reads one cycle ahead
// and keeps a 2-entry skid buffer so the output stream runs at full rate.
module wl_afifo_rdstage #(
    parameter int W = 32
) (
    input  logic         rclk,
    input  logic         rrst_b,
    input  logic         rclr,
    input  logic         rempty,
    output logic         re,
    input  logic [W-1:0] ram_rdata,
    output logic [W-1:0] dout,
    output logic         dout_vld,
    input  logic         dout_rdy,
    output logic [1:0]   occ
);

    logic [1:0]   occ_q, occ_d;
    logic         inflight_q, inflight_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;

    logic         pop;
    logic [1:0]   committed;
    logic [1:0]   occ_left;
    logic [2:0]   occ_sum;

    assign occ      = occ_q;
    assign dout     = head_q;
    assign dout_vld = (occ_q != 2'd0);

    always_comb begin
        pop        = dout_vld & dout_rdy;
        committed  = occ_q + {1'b0, inflight_q};
        // A new read is allowed only if a slot is guaranteed by the time its data lands.
        re         = rrst_b & ~rempty & ~rclr &
                     ((committed < 2'd2) | ((committed == 2'd2) & pop));
        occ_left   = occ_q - {1'b0, pop};
        occ_sum    = {1'b0, occ_left} + {2'b00, inflight_q};

        head_d     = head_q;
        tail_d     = tail_q;
        inflight_d = re;
        occ_d      = occ_sum[1:0];

        if (pop && occ_q == 2'd2)
            head_d = tail_q;
        if (inflight_q) begin
            if (occ_left == 2'd0)
                head_d = ram_rdata;
            else
                tail_d = ram_rdata;
        end

        if (rclr) begin
            occ_d      = 2'd0;
            inflight_d = 1'b0;
            head_d     = head_q;
            tail_d     = tail_q;
        end
    end

    always_ff @(posedge rclk) begin
        if (!rrst_b) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            assert (rclr || occ_sum <= 3'd2);
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

endmodule

// File: tb/tb_wl_afifo_rdstage.sv
// Directed bench for wl_afifo_rdstage with a simple FIFO/RAM model that
// returns data one cycle after re.
module tb_wl_afifo_rdstage;
    localparam int W = 32;

    logic         rclk = 1'b0;
    logic         rrst_b, rclr, rempty, re, dout_vld, dout_rdy;
    logic [W-1:0] ram_rdata, dout;
    logic [1:0]   occ;

    logic [W-1:0] mem [0:8191];
    int           wr_ptr = 0;
    int           rd_ptr = 0;
    logic         hold_empty;
    int           checks = 0;
    int           errors = 0;

    always #5 rclk = ~rclk;

    assign rempty = hold_empty | (rd_ptr == wr_ptr);

    always @(posedge rclk) begin
        if (re) begin
            ram_rdata <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    wl_afifo_rdstage #(.W(W)) dut (
        .rclk(rclk), .rrst_b(rrst_b), .rclr(rclr), .rempty(rempty), .re(re),
        .ram_rdata(ram_rdata), .dout(dout), .dout_vld(dout_vld),
        .dout_rdy(dout_rdy), .occ(occ)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge rclk);
        #2;
    endtask

    task automatic push(input logic [W-1:0] d);
        mem[wr_ptr] = d;
        wr_ptr++;
    endtask

    initial begin
        logic [W-1:0] wds [0:4];
        int start, sb;
        ram_rdata  = '0;
        rrst_b     = 1'b0;
        rclr       = 1'b0;
        dout_rdy   = 1'b1;
        hold_empty = 1'b0;

        // Reset with data waiting: re must stay low, state cleared.
        wds[0] = 32'hA0A0_0001; wds[1] = 32'hB0B0_0002; wds[2] = 32'hC0C0_0003;
        wds[3] = 32'hD0D0_0004; wds[4] = 32'hE0E0_0005;
        for (int i = 0; i < 5; i++) push(wds[i]);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("rst_re", re, 0);
            tick;
        end
        chk("rst_occ", occ, 0);
        chk("rst_vld", dout_vld, 0);
        chk("rst_dout", dout, 0);
        chk("rst_rd", rd_ptr, 0);

        // Streaming at full rate.
        rrst_b = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("s_re", re, (c < 5) ? 1 : 0);
            chk("s_vld", dout_vld, (c >= 2 && c <= 6) ? 1 : 0);
            if (c >= 2 && c <= 6) chk("s_dout", dout, wds[c-2]);
            tick;
        end
        chk("s_occ_end", occ, 0);

        // Backpressure: two reads then stall with dout stable.
        start = rd_ptr;
        for (int i = 0; i < 4; i++) push(32'hF000_0000 + i);
        dout_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_re", re, (c < 2) ? 1 : 0);
            if (c >= 2) chk("bp_dout", dout, 32'hF000_0000);
            if (c >= 3) chk("bp_occ", occ, 2);
            tick;
        end
        chk("bp_reads", rd_ptr - start, 2);
        dout_rdy = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bpr_re", re, (c < 2) ? 1 : 0);
            chk("bpr_vld", dout_vld, (c < 4) ? 1 : 0);
            if (c < 4) chk("bpr_dout", dout, 32'hF000_0000 + c);
            tick;
        end

        // Clear with a word in head and another in flight.
        for (int i = 0; i < 3; i++) push(32'h6000_0000 + i);
        dout_rdy = 1'b0;
        tick; tick;
        #1;
        chk("clr_pre_occ", occ, 1);
        chk("clr_pre_dout", dout, 32'h6000_0000);
        dout_rdy = 1'b1;
        rclr     = 1'b1;
        #1;
        chk("clr_re", re, 0);
        tick;
        rclr = 1'b0;
        #1;
        chk("clr_occ", occ, 0);
        chk("clr_vld", dout_vld, 0);
        chk("clr_re_after", re, 1);
        tick;
        #1;
        chk("clr_vld2", dout_vld, 0);
        tick;
        #1;
        chk("clr_vld3", dout_vld, 1);
        chk("clr_dout", dout, 32'h6000_0002);
        tick;
        #1;
        chk("clr_vld4", dout_vld, 0);

        // Reset mid-transfer.
        for (int i = 0; i < 3; i++) push(32'h7000_0000 + i);
        dout_rdy = 1'b0;
        tick; tick;
        #1;
        chk("mr_pre_occ", occ, 1);
        rrst_b = 1'b0;
        dout_rdy = 1'b1;
        #1;
        chk("mr_re", re, 0);
        tick;
        rrst_b = 1'b1;
        #1;
        chk("mr_occ", occ, 0);
        chk("mr_dout", dout, 0);
        chk("mr_vld", dout_vld, 0);
        tick; tick;
        #1;
        chk("mr_next_dout", dout, 32'h7000_0002);
        chk("mr_next_vld", dout_vld, 1);
        tick;

        // Single word.
        start = rd_ptr;
        push(32'h1234_5678);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("sw_re", re, (c == 0) ? 1 : 0);
            chk("sw_vld", dout_vld, (c == 2) ? 1 : 0);
            if (c == 2) chk("sw_dout", dout, 32'h1234_5678);
            tick;
        end
        chk("sw_reads", rd_ptr - start, 1);
        chk("sw_occ", occ, 0);

        // Random flow control with scoreboard.
        sb = rd_ptr;
        for (int i = 0; i < 3000; i++) push($urandom);
        for (int c = 0; c < 10000; c++) begin
            hold_empty = ($urandom_range(0, 3) == 0);
            dout_rdy   = $urandom_range(0, 1);
            #1;
            chk("r_underflow", re & rempty, 0);
            chk("r_occ_ok", (occ != 2'd3), 1);
            if (dout_vld && dout_rdy) begin
                chk("r_data", dout, mem[sb]);
                sb++;
            end
            tick;
        end
        hold_empty = 1'b1;
        dout_rdy   = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (dout_vld) begin
                chk("r_drain", dout, mem[sb]);
                sb++;
            end
            tick;
        end
        chk("r_count", sb, rd_ptr);
        chk("r_occ_end", occ, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
